// File: rtl/cios_final_reduce_if.sv
// Word-stream bundle between the CIOS datapath, the final reduction and its consumer.
interface cios_final_reduce_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWORDS = 8
);
    logic [WIDTH*NWORDS-1:0] n_mod;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_word;
    logic                    in_top;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_word;
    logic                    out_last;
    logic                    sub_taken;

    // Reduction block side
    modport slave (
        input  n_mod,
        input  in_valid,
        output in_ready,
        input  in_word,
        input  in_top,
        output out_valid,
        input  out_ready,
        output out_word,
        output out_last,
        output sub_taken
    );

    // Producer / consumer side
    modport master (
        output n_mod,
        output in_valid,
        input  in_ready,
        output in_word,
        output in_top,
        input  out_valid,
        output out_ready,
        input  out_word,
        input  out_last,
        input  sub_taken
    );
endinterface

// File: rtl/cios_final_reduce.sv
// Montgomery final conditional subtraction, word-serial: collects T, computes
// T-N alongside, then replays either T or T-N over a valid/ready stream.
module cios_final_reduce #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NWORDS = 8
) (
    input logic                 clk,
    input logic                 rst,
    cios_final_reduce_if.slave  bus
);
    localparam int unsigned IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned DW   = WIDTH + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [IDXW-1:0]              in_cnt_q, in_cnt_d;
    logic [IDXW-1:0]              out_cnt_q, out_cnt_d;
    logic                         borrow_q, borrow_d;
    logic [NWORDS-1:0][WIDTH-1:0] tbuf_q, tbuf_d;
    logic [NWORDS-1:0][WIDTH-1:0] dbuf_q, dbuf_d;
    logic                         out_valid_q, out_valid_d;
    logic [WIDTH-1:0]             out_word_q, out_word_d;
    logic                         out_last_q, out_last_d;
    logic                         sub_taken_q, sub_taken_d;

    logic [NWORDS-1:0][WIDTH-1:0] n_words;
    logic                         in_ready;
    logic                         in_acc;
    logic                         out_acc;
    logic                         in_last;
    logic                         borrow_in;
    logic [DW-1:0]                diff;
    logic                         sel;
    logic [IDXW-1:0]              out_nxt;

    assign n_words = bus.n_mod;
    assign in_acc  = bus.in_valid & in_ready;
    assign out_acc = out_valid_q & bus.out_ready;
    assign in_last = (in_cnt_q == LAST_IDX);
    assign out_nxt = out_cnt_q + IDXW'(1);

    // Word k of T - N; the chain starts with no borrow at word 0
    always_comb begin
        borrow_in = (in_cnt_q == '0) ? 1'b0 : borrow_q;
        diff      = {1'b0, bus.in_word} - {1'b0, n_words[in_cnt_q]} - DW'(borrow_in);
        sel       = bus.in_top | ~diff[WIDTH];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: collect NWORDS inputs, then send NWORDS outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_acc) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (in_acc && in_last) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_acc && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs: input side is open whenever not replaying
    always_comb begin
        in_ready = 1'b0;
        if (state_q != SEND) begin
            in_ready = 1'b1;
        end
    end

    // Datapath next values: buffer fill, borrow chain and output replay
    always_comb begin
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        borrow_d    = borrow_q;
        tbuf_d      = tbuf_q;
        dbuf_d      = dbuf_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        sub_taken_d = sub_taken_q;

        if (in_acc) begin
            tbuf_d[in_cnt_q] = bus.in_word;
            dbuf_d[in_cnt_q] = diff[WIDTH-1:0];
            borrow_d         = diff[WIDTH];
            if (in_last) begin
                // Word 0 is already buffered, so the first output can be loaded now
                in_cnt_d    = '0;
                out_cnt_d   = '0;
                sub_taken_d = sel;
                out_valid_d = 1'b1;
                out_word_d  = sel ? dbuf_q[0] : tbuf_q[0];
                out_last_d  = 1'b0;
            end else begin
                in_cnt_d = in_cnt_q + IDXW'(1);
            end
        end

        if (out_acc) begin
            if (out_last_q) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                sub_taken_d = 1'b0;
                out_cnt_d   = '0;
            end else begin
                out_cnt_d  = out_nxt;
                out_word_d = sub_taken_q ? dbuf_q[out_nxt] : tbuf_q[out_nxt];
                out_last_d = (out_nxt == LAST_IDX);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            borrow_q    <= 1'b0;
            tbuf_q      <= '0;
            dbuf_q      <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
            sub_taken_q <= 1'b0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            borrow_q    <= borrow_d;
            tbuf_q      <= tbuf_d;
            dbuf_q      <= dbuf_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            sub_taken_q <= sub_taken_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_last  = out_last_q;
    assign bus.sub_taken = sub_taken_q;

endmodule

// File: tb/tb_cios_final_reduce.sv
// Scoreboard bench for cios_final_reduce with WIDTH=32, NWORDS=4.
module tb_cios_final_reduce;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned OPW    = WIDTH * NWORDS;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             last;
        logic             sub;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    cios_final_reduce_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus ();

    cios_final_reduce #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden model: R = (top || T >= N) ? (T - N) mod 2^OPW : T
    task automatic push_expected(input logic [OPW-1:0] t, input logic [OPW-1:0] n, input logic top);
        logic           s;
        logic [OPW-1:0] r;
        exp_t           e;
        s = top || (t >= n);
        r = s ? (t - n) : t;
        for (int k = 0; k < int'(NWORDS); k++) begin
            e.word = r[k*WIDTH +: WIDTH];
            e.last = (k == int'(NWORDS) - 1);
            e.sub  = s;
            sb.push_back(e);
        end
    endtask

    // Feed one operand, optionally with random idle cycles between words
    task automatic drive_operand(input logic [OPW-1:0] t, input logic top, input int gap_pct);
        int guard;
        for (int k = 0; k < int'(NWORDS); k++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_word  = $urandom;
                bus.in_top   = 1'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_word  = t[k*WIDTH +: WIDTH];
            bus.in_top   = (k == int'(NWORDS) - 1) ? top : 1'($urandom);
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout word=%0d in_ready=%b required=1", k, bus.in_ready);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_top   = 1'b0;
    endtask

    // Consume one result, comparing against the scoreboard and checking stall stability
    task automatic drain(input string name, input int rdy_pct);
        int               cyc;
        logic             done;
        logic             rdy;
        logic             prev_stall;
        logic [WIDTH-1:0] prev_word;
        logic             prev_last;
        exp_t             e;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_word  = '0;
        prev_last  = 1'b0;
        cyc        = 0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency out_valid=%b required=1", name, bus.out_valid);
        end
        while (!done && cyc < 300) begin
            rdy = (rdy_pct >= 100) || (int'($urandom_range(99)) < rdy_pct);
            bus.out_ready = rdy;
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s_valid_drop cycle=%0d out_valid=%b required=1", name, cyc, bus.out_valid);
            end else begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_in_ready_send in_ready=%b required=0", name, bus.in_ready);
                end
                if (prev_stall) begin
                    checks++;
                    if (bus.out_word !== prev_word || bus.out_last !== prev_last) begin
                        failures++;
                        $display("FAIL %s_stall_hold word=%h last=%b required word=%h last=%b",
                                 name, bus.out_word, bus.out_last, prev_word, prev_last);
                    end
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_scoreboard_empty word=%h", name, bus.out_word);
                    done = 1'b1;
                end else begin
                    checks++;
                    if (bus.sub_taken !== sb[0].sub) begin
                        failures++;
                        $display("FAIL %s_sub_taken got=%b required=%b", name, bus.sub_taken, sb[0].sub);
                    end
                    if (rdy) begin
                        e = sb.pop_front();
                        checks++;
                        if (bus.out_word !== e.word || bus.out_last !== e.last) begin
                            failures++;
                            $display("FAIL %s_word got=%h last=%b required=%h last=%b",
                                     name, bus.out_word, bus.out_last, e.word, e.last);
                        end
                        done = e.last;
                    end
                end
                prev_stall = !rdy;
                prev_word  = bus.out_word;
                prev_last  = bus.out_last;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout cycles=%0d required<300", name, cyc);
            sb.delete();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.sub_taken !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_return_idle valid=%b last=%b sub=%b in_ready=%b required 0 0 0 1",
                     name, bus.out_valid, bus.out_last, bus.sub_taken, bus.in_ready);
        end
    endtask

    task automatic run_operand(input string name, input logic [OPW-1:0] n, input logic [OPW-1:0] t,
                               input logic top, input int gap_pct, input int rdy_pct);
        bus.n_mod = n;
        push_expected(t, n, top);
        drive_operand(t, top, gap_pct);
        drain(name, rdy_pct);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_word !== '0 || bus.out_last !== 1'b0 ||
            bus.sub_taken !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s valid=%b word=%h last=%b sub=%b in_ready=%b required 0 0 0 0 1",
                     name, bus.out_valid, bus.out_word, bus.out_last, bus.sub_taken, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset_state");
        rst = 1'b0;
        tick();
        check_reset_outputs("after_reset_release");
    endtask

    task automatic test_no_sub();
        run_operand("no_sub", 128'h5, 128'h3, 1'b0, 0, 100);
    endtask

    task automatic test_equal();
        run_operand("equal", 128'hFFFFFFFF_00000000_12345678_9ABCDEF0,
                    128'hFFFFFFFF_00000000_12345678_9ABCDEF0, 1'b0, 0, 100);
    endtask

    task automatic test_borrow_ripple();
        run_operand("borrow_ripple", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFF9,
                    128'h80000000_00000000_00000000_00000000, 1'b0, 0, 100);
    endtask

    task automatic test_top_wrap();
        run_operand("top_wrap", 128'h80000000_00000000_00000000_00000001, 128'h2, 1'b1, 0, 100);
    endtask

    task automatic test_back_to_back();
        run_operand("b2b_a", 128'h1234, 128'h1233, 1'b0, 0, 100);
        run_operand("b2b_b", 128'h1234, 128'h1235, 1'b0, 0, 100);
    endtask

    task automatic test_random_stall();
        logic [OPW-1:0] n;
        logic [OPW-1:0] t;
        logic           top;
        for (int i = 0; i < 8; i++) begin
            n   = {$urandom, $urandom, $urandom, $urandom};
            t   = (i % 2 == 0) ? n + OPW'($urandom_range(255)) : {$urandom, $urandom, $urandom, $urandom};
            top = (i % 3 == 0);
            run_operand("random_stall", n, t, top, 30, 50);
        end
    endtask

    task automatic test_reset_mid();
        bus.n_mod = 128'h11111111_22222222_33333333_44444444;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = 32'hDEADBEEF;
            bus.in_top   = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_top   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_async");
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset_mid_released");
        run_operand("after_reset_mid", 128'h11111111_22222222_33333333_44444444,
                    128'h22222222_33333333_44444444_55555555, 1'b0, 0, 100);
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        checks        = 0;
        failures      = 0;
        bus.n_mod     = '0;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.in_top    = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_no_sub();
        test_equal();
        test_borrow_ripple();
        test_top_wrap();
        test_back_to_back();
        test_random_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
